// File: rtl/cheb_seq.sv
// cheb_seq: streams the Chebyshev terms T_0..T_n of one signed fixed-point
// argument x over a valid/ready port. Terms from T_2 on are produced with the
// recurrence T_k = 2*x*T_{k-1} - T_{k-2} using an external pipelined
// multiplier; this block only sequences operands and post-processes products.
module cheb_seq #(
    parameter int WL       = 16,
    parameter int FRAC     = WL - 2,
    parameter int N_MAX    = 16,
    parameter int MULT_LAT = 2
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           start,
    input  logic signed [WL-1:0]           x_in,
    input  logic [$clog2(N_MAX+1)-1:0]     n_in,
    input  logic                           abort,
    output logic                           busy,
    output logic signed [WL-1:0]           mult_a,
    output logic signed [WL-1:0]           mult_b,
    output logic                           mult_go,
    input  logic signed [2*WL-1:0]         mult_p,
    output logic                           t_valid,
    input  logic                           t_ready,
    output logic signed [WL-1:0]           t_data,
    output logic [$clog2(N_MAX+1)-1:0]     t_idx,
    output logic                           done,
    output logic                           sat
);

    localparam int IW = $clog2(N_MAX + 1);
    localparam int CW = (MULT_LAT > 2) ? $clog2(MULT_LAT - 1) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'((MULT_LAT > 2) ? (MULT_LAT - 2) : 0);
    localparam logic [IW-1:0] N_LIMIT = IW'(N_MAX);
    localparam logic signed [WL-1:0] ONE = WL'(2 ** FRAC);

    typedef enum logic [2:0] {
        IDLE,
        EMIT,
        ISSUE,
        WAIT,
        CALC
    } state_t;

    state_t state_q;
    state_t state_d;

    logic signed [WL-1:0] x_q;
    logic signed [WL-1:0] t_prev1_q;
    logic signed [WL-1:0] t_prev2_q;
    logic signed [WL-1:0] t_data_q;
    logic [IW-1:0]        n_q;
    logic [IW-1:0]        k_q;
    logic [CW-1:0]        wait_cnt_q;
    logic                 done_q;
    logic                 sat_q;

    logic                 start_ok;
    logic                 accept;
    logic signed [2*WL-1:0] prod_shift;
    logic signed [WL+2:0]   r_wide;
    logic signed [WL-1:0]   r_sat;
    logic                   r_clamp;
    logic                   prod_unused;

    // A start is only honoured when fully idle, including the done cycle
    assign start_ok = (state_q == IDLE) && !done_q && start;
    assign accept   = (state_q == EMIT) && t_ready;

    // Product rescale: 2*x*T/2^FRAC is the product shifted right by FRAC-1
    assign prod_shift  = mult_p >>> (FRAC - 1);
    assign prod_unused = ^prod_shift[2*WL-1:WL+3];
    assign r_wide      = $signed(prod_shift[WL+2:0])
                       - $signed({{3{t_prev2_q[WL-1]}}, t_prev2_q});

    // Clamp the recurrence result into the WL-bit signed range
    always_comb begin
        r_clamp = (r_wide[WL+2:WL-1] != {4{r_wide[WL+2]}});
        if (!r_clamp) begin
            r_sat = r_wide[WL-1:0];
        end else if (r_wide[WL+2]) begin
            r_sat = {1'b1, {(WL-1){1'b0}}};
        end else begin
            r_sat = {1'b0, {(WL-1){1'b1}}};
        end
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort pulls any active state back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (k_q == n_q) begin
                        state_d = IDLE;
                    end else if (k_q == '0) begin
                        state_d = EMIT;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (MULT_LAT == 1) begin
                    state_d = CALC;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == '0) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy    = (state_q != IDLE) || done_q;
        t_valid = (state_q == EMIT);
        mult_go = (state_q == ISSUE);
    end

    // Datapath: argument capture, term history, emitted term and flags
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_q        <= '0;
            n_q        <= '0;
            k_q        <= '0;
            t_prev1_q  <= '0;
            t_prev2_q  <= '0;
            t_data_q   <= '0;
            wait_cnt_q <= '0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        x_q       <= x_in;
                        n_q       <= (n_in > N_LIMIT) ? N_LIMIT : n_in;
                        k_q       <= '0;
                        t_prev1_q <= ONE;
                        t_prev2_q <= '0;
                        t_data_q  <= ONE;
                        sat_q     <= 1'b0;
                    end
                end
                EMIT: begin
                    if (accept) begin
                        if (k_q == n_q) begin
                            done_q <= !abort;
                        end else if (k_q == '0) begin
                            k_q       <= IW'(1);
                            t_data_q  <= x_q;
                            t_prev1_q <= x_q;
                            t_prev2_q <= ONE;
                        end else begin
                            k_q <= k_q + IW'(1);
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt_q <= WAIT_LOAD;
                end
                WAIT: begin
                    if (wait_cnt_q != '0) begin
                        wait_cnt_q <= wait_cnt_q - CW'(1);
                    end
                end
                CALC: begin
                    if (!abort) begin
                        t_data_q  <= r_sat;
                        t_prev1_q <= r_sat;
                        t_prev2_q <= t_prev1_q;
                        if (r_clamp) begin
                            sat_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mult_a = x_q;
    assign mult_b = t_prev1_q;
    assign t_data = t_data_q;
    assign t_idx  = k_q;
    assign done   = done_q;
    assign sat    = sat_q;

endmodule

// File: tb/tb_cheb_seq.sv
// tb_cheb_seq: scoreboard bench for cheb_seq with a two-stage multiplier model.
module tb_cheb_seq;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        start;
    logic [15:0] x_in;
    logic [4:0]  n_in;
    logic        abort;
    logic        busy;
    logic [15:0] mult_a;
    logic [15:0] mult_b;
    logic        mult_go;
    logic [31:0] mult_p;
    logic        t_valid;
    logic        t_ready;
    logic [15:0] t_data;
    logic [4:0]  t_idx;
    logic        done;
    logic        sat;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_count = 0;
    int mgo_count = 0;
    int term_cycs[$];
    logic [20:0] exp_q[$];
    logic        ready_toggle = 1'b0;
    logic [15:0] ready_pat = 16'b1001_0011_0100_1101;

    logic signed [15:0] ma_r;
    logic signed [15:0] mb_r;
    logic signed [31:0] mp_r;

    cheb_seq dut (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start),
        .x_in    (x_in),
        .n_in    (n_in),
        .abort   (abort),
        .busy    (busy),
        .mult_a  (mult_a),
        .mult_b  (mult_b),
        .mult_go (mult_go),
        .mult_p  (mult_p),
        .t_valid (t_valid),
        .t_ready (t_ready),
        .t_data  (t_data),
        .t_idx   (t_idx),
        .done    (done),
        .sat     (sat)
    );

    always #5 clock = ~clock;

    // External multiplier: registered operands, registered product
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ma_r <= '0;
            mb_r <= '0;
            mp_r <= '0;
        end else begin
            ma_r <= mult_a;
            mb_r <= mult_b;
            mp_r <= ma_r * mb_r;
        end
    end
    assign mult_p = mp_r;

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    // Downstream ready: held high, or following a fixed pseudo-random pattern
    initial begin
        t_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            t_ready = ready_toggle ? ready_pat[cyc % 16] : 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushTerm(input int idx, input logic [15:0] data);
        exp_q.push_back({5'(idx), data});
    endtask

    task automatic applyStimulus(input logic [15:0] x, input logic [4:0] n);
        term_cycs.delete();
        mgo_count = 0;
        start_cyc = cyc;
        start = 1'b1;
        x_in = x;
        n_in = n;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int d0;
        int i;
        d0 = done_count;
        i = 0;
        while (done_count == d0 && i < budget) begin
            @(posedge clock);
            i++;
        end
        #1;
        checkOutput({name, "_done"}, done_count - d0, 1);
        checkOutput({name, "_busy_low"}, {31'd0, busy}, 0);
        checkOutput({name, "_leftover"}, exp_q.size(), 0);
        if (term_cycs.size() > 0) begin
            checkOutput({name, "_done_lat"}, done_cyc - term_cycs[term_cycs.size()-1], 1);
        end
    endtask

    task automatic waitMultGo(input string name);
        int i;
        i = 0;
        while (i < 30) begin
            @(negedge clock);
            if (mult_go) break;
            i++;
        end
        checkOutput({name, "_mult_go_seen"}, {31'd0, mult_go}, 1);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_busy"}, {31'd0, busy}, 0);
        checkOutput({name, "_tvalid"}, {31'd0, t_valid}, 0);
        checkOutput({name, "_term"}, {11'd0, t_idx, t_data}, 0);
        checkOutput({name, "_done_sat_go"}, {29'd0, done, sat, mult_go}, 0);
        checkOutput({name, "_mult_ab"}, {mult_a, mult_b}, 0);
    endtask

    // Monitor: pops expected terms on each handshake and checks stall stability
    initial begin
        logic        prev_stall;
        logic [20:0] prev_term;
        logic [20:0] exp;
        prev_stall = 1'b0;
        prev_term = '0;
        forever begin
            @(negedge clock);
            if (resetn) begin
                if (mult_go) mgo_count++;
                if (done) begin
                    done_count++;
                    done_cyc = cyc;
                end
                if (prev_stall && t_valid) begin
                    checkOutput("hold_stable", {11'd0, t_idx, t_data}, {11'd0, prev_term});
                end
                if (t_valid && t_ready) begin
                    term_cycs.push_back(cyc);
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("[TB] FAIL unexpected_term: got idx %0d data 0x%0h, expected none",
                                 t_idx, t_data);
                    end else begin
                        compared--;
                        exp = exp_q.pop_front();
                        checkOutput("term", {11'd0, t_idx, t_data}, {11'd0, exp});
                    end
                end
                prev_stall = t_valid && !t_ready;
                prev_term = {t_idx, t_data};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        start = 1'b0;
        abort = 1'b0;
        x_in = '0;
        n_in = '0;

        // Reset state
        #1 resetn = 1'b0;
        #1 checkAllZero("reset");
        #5 resetn = 1'b1;
        @(posedge clock);
        #1;

        // x=0.5, n=3, ready held high
        pushTerm(0, 16'h4000); pushTerm(1, 16'h2000);
        pushTerm(2, 16'hE000); pushTerm(3, 16'hC000);
        applyStimulus(16'h2000, 5'd3);
        waitDone("half", 100);
        checkOutput("half_count", term_cycs.size(), 4);
        checkOutput("half_lat0", term_cycs[0] - start_cyc, 1);
        checkOutput("half_gap1", term_cycs[1] - term_cycs[0], 1);
        checkOutput("half_gap2", term_cycs[2] - term_cycs[1], 4);
        checkOutput("half_gap3", term_cycs[3] - term_cycs[2], 4);
        checkOutput("half_sat", {31'd0, sat}, 0);
        checkOutput("half_mult_go", mgo_count, 2);

        // x=1.5, n=2: T_2 = 3.5 saturates
        pushTerm(0, 16'h4000); pushTerm(1, 16'h6000); pushTerm(2, 16'h7FFF);
        applyStimulus(16'h6000, 5'd2);
        waitDone("satrun", 100);
        checkOutput("satrun_sat", {31'd0, sat}, 1);

        // x=0, n=2: sat cleared by the start
        pushTerm(0, 16'h4000); pushTerm(1, 16'h0000); pushTerm(2, 16'hC000);
        applyStimulus(16'h0000, 5'd2);
        checkOutput("zero_sat_cleared", {31'd0, sat}, 0);
        waitDone("zero", 100);
        checkOutput("zero_sat", {31'd0, sat}, 0);

        // x=0.5, n=3 with a toggling ready
        ready_toggle = 1'b1;
        pushTerm(0, 16'h4000); pushTerm(1, 16'h2000);
        pushTerm(2, 16'hE000); pushTerm(3, 16'hC000);
        applyStimulus(16'h2000, 5'd3);
        waitDone("stall", 300);
        checkOutput("stall_mult_go", mgo_count, 2);
        ready_toggle = 1'b0;
        @(posedge clock);
        #1;

        // n=0: only T_0
        pushTerm(0, 16'h4000);
        applyStimulus(16'h2000, 5'd0);
        waitDone("n0", 50);
        checkOutput("n0_mult_go", mgo_count, 0);

        // n=1, x=-1.0
        pushTerm(0, 16'h4000); pushTerm(1, 16'hC000);
        applyStimulus(16'hC000, 5'd1);
        waitDone("n1", 50);
        checkOutput("n1_mult_go", mgo_count, 0);

        // n=20 clamps to 16; x=0 gives 1, 0, -1, 0, 1, ...
        for (int k = 0; k <= 16; k++) begin
            if (k % 2 == 1) pushTerm(k, 16'h0000);
            else if (k % 4 == 0) pushTerm(k, 16'h4000);
            else pushTerm(k, 16'hC000);
        end
        applyStimulus(16'h0000, 5'd20);
        waitDone("clamp", 300);
        checkOutput("clamp_count", term_cycs.size(), 17);
        checkOutput("clamp_mult_go", mgo_count, 15);

        // Abort in WAIT during n=5; a start mid-run is ignored
        d0 = done_count;
        pushTerm(0, 16'h4000); pushTerm(1, 16'h2000);
        applyStimulus(16'h2000, 5'd5);
        start = 1'b1;
        x_in = 16'h7000;
        n_in = 5'd1;
        @(posedge clock);
        #1;
        start = 1'b0;
        waitMultGo("abort");
        @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 0);
        checkOutput("abort_tvalid", {31'd0, t_valid}, 0);
        repeat (10) @(posedge clock);
        #1;
        checkOutput("abort_no_done", done_count - d0, 0);
        checkOutput("abort_leftover", exp_q.size(), 0);
        checkOutput("abort_terms", term_cycs.size(), 2);

        // Fresh run after abort: x=-1.0, n=3
        pushTerm(0, 16'h4000); pushTerm(1, 16'hC000);
        pushTerm(2, 16'h4000); pushTerm(3, 16'hC000);
        applyStimulus(16'hC000, 5'd3);
        waitDone("post_abort", 100);

        // Asynchronous reset in CALC
        pushTerm(0, 16'h4000); pushTerm(1, 16'h2000);
        applyStimulus(16'h2000, 5'd3);
        waitMultGo("rst");
        @(posedge clock);
        @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        checkAllZero("midreset");
        #2;
        resetn = 1'b1;
        checkOutput("midreset_leftover", exp_q.size(), 0);
        @(posedge clock);
        #1;
        pushTerm(0, 16'h4000); pushTerm(1, 16'h2000);
        applyStimulus(16'h2000, 5'd1);
        waitDone("after_reset", 50);
        checkOutput("after_reset_lat0", term_cycs[0] - start_cyc, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cheb_seq.md
# cheb_seq

Sequencer that generates the Chebyshev polynomial terms T_0(x) … T_n(x) for one signed fixed-point argument x. It applies the recurrence T_k = 2·x·T_{k-1} − T_{k-2}. The block owns no multiplier. It drives one external pipelined signed multiplier: registered inputs, registered product, MULT_LAT cycles from operand presentation to product. It sits between the argument source and the downstream coefficient-accumulate stage, and streams the terms out over a valid/ready handshake.

## Interface
- WL, 16: word length of x and of every T_k; signed two's complement.
- FRAC, WL-2: fractional bits. 1.0 = 2^FRAC; 0x4000 at defaults.
- N_MAX, 16: highest order accepted.
- MULT_LAT, 2: multiplier latency in cycles, operands to product. Must be ≥ 1.
- clock  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only while busy=0.
- x_in  in  WL  argument; captured on an accepted start.
- n_in  in  ceil(log2(N_MAX+1))  highest order; captured on an accepted start. Values above N_MAX are clamped to N_MAX.
- abort  in  1  synchronous run cancel.
- busy  out  1  high from the cycle after an accepted start until the cycle after done or abort.
- mult_a  out  WL  multiplier operand = captured x.
- mult_b  out  WL  multiplier operand = T_{k-1}.
- mult_go  out  1  high in the cycle the multiplier must sample mult_a/mult_b.
- mult_p  in  2·WL  signed product from the multiplier.
- t_valid  out  1  t_data/t_idx hold a valid term.
- t_ready  in  1  downstream accepts the term.
- t_data  out  WL  term value T_k.
- t_idx  out  ceil(log2(N_MAX+1))  k.
- done  out  1  one-cycle pulse after the last term is accepted.
- sat  out  1  sticky: some term of the current run saturated. Cleared on an accepted start.

## Operation
- States: IDLE, EMIT, ISSUE, WAIT, CALC.
- IDLE: start=1 latches x, n, k=0, t_prev1=1.0, t_prev2=0, clears sat, and goes to EMIT. The emitted data is T_0 = 2^FRAC.
- EMIT: t_valid=1, t_data/t_idx stable until t_ready=1. Acceptance happens in a cycle with t_valid & t_ready.
- After an accepted term with k == n: pulse done, go to IDLE.
- After an accepted term with k == 0: emit T_1 = x next (EMIT again, no multiply). Set t_prev2 = 1.0 and t_prev1 = x.
- Otherwise: k ← k+1, go to ISSUE.
- ISSUE: mult_go=1 for exactly 1 cycle. Go to WAIT for MULT_LAT−1 cycles, or straight to CALC if MULT_LAT=1.
- CALC: mult_p is valid in this cycle, exactly MULT_LAT cycles after ISSUE. Compute r = (mult_p >>> (FRAC−1)) − t_prev2.
  - Arithmetic shift: truncation toward −inf. Intermediate width WL+3, no overflow.
  - Saturate r to [−2^(WL−1), 2^(WL−1)−1]; set sat on clamp.
  - Register the result as t_data. Shift the history: t_prev2 ← t_prev1, t_prev1 ← result. Go to EMIT.
- mult_a/mult_b are always driven from the registers x and t_prev1. mult_go is the only qualifier; the multiplier may sample them every cycle harmlessly.
- A start while busy=1 is ignored.
- abort=1 in any non-IDLE state: go to IDLE next edge, t_valid=0, no done, sat retained. Any product in flight is discarded.
- Simultaneous abort and start in IDLE: start wins, since abort has no effect in IDLE.
- Simultaneous abort and acceptance of the final term: the term counts as accepted, no done, IDLE.
- n_in = 0: emit T_0 only, then done.
- n_in = 1: emit T_0, T_1, then done; mult_go never asserts.

## Timing
- Reset (asynchronous, immediate): state IDLE; all outputs 0. This includes busy, t_valid, t_data, t_idx, done, sat, mult_a, mult_b and mult_go. Internal registers are cleared. Reset mid-run abandons the run with no done.
- start accepted at edge e → t_valid=1 for T_0 in the cycle after e.
- With t_ready held high:
  - T_0 and T_1 on consecutive cycles.
  - Each later term every MULT_LAT+2 cycles: EMIT → ISSUE → WAIT×(MULT_LAT−1) → CALC → EMIT.
  - For a whole run with n ≥ 1: the first term appears 1 cycle after start; the last term appears (n−1)·(MULT_LAT+2)+1 cycles after T_0; done follows one cycle after the last acceptance.
- t_ready low stalls only in EMIT. No multiplier operation is in flight during EMIT.
- busy falls in the cycle after done. A new start is accepted in that cycle.

## Test plan
- WL=16, FRAC=14, MULT_LAT=2; x=0x2000 (0.5), n=3, t_ready=1:
  - t_data sequence 0x4000, 0x2000, 0xE000, 0xC000 with t_idx 0..3.
  - Gaps between terms: 1, 4, 4 cycles.
  - done 1 cycle after the last term; sat=0.
- x=0x6000 (1.5), n=2 → T_2 = 0x7FFF (saturated), sat=1. A following start with x=0 clears sat.
- x=0x2000, n=3 with t_ready toggling 1-0-0-1 pseudo-randomly → identical data sequence. t_data/t_idx stable while t_valid & !t_ready. Exactly one mult_go per term k ≥ 2.
- n=0 → single term 0x4000, done, mult_go never high. n=1, x=0xC000 → terms 0x4000, 0xC000, no mult_go. n=20 → clamped to N_MAX=16, last t_idx=16.
- abort asserted in WAIT during a run with n=5 → idle next cycle, no done, no further t_valid. A start during the run is ignored. A start after the abort completes a fresh run correctly.
- resetn pulled low asynchronously mid-CALC → all outputs 0 immediately, without a clock edge. After release, start yields T_0 on the next cycle.
